// File: rtl/pll_reset_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_pkg
//
// Shared definitions for the PLL reset sequencer:
//   - state_t         : 2-bit sequencer state (WAIT/QUALIFY/HOLD/RUN)
//   - DEF_* constants : default parameter values used by the top
//   - counter_width() : width of the shared qualify/hold counter
//
// No ports (package).
// ---------------------------------------------------------------------------
package pll_reset_pkg;

    typedef enum logic [1:0] {
        WAIT    = 2'd0,
        QUALIFY = 2'd1,
        HOLD    = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES   = 16;

    // clog2(max(a,b)) bits are enough because the counter only ever holds
    // values up to max(a,b)-1. A 1-cycle window would give zero bits, so the
    // width is floored at 1.
    function automatic int counter_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// ---------------------------------------------------------------------------
// lock_sync
//
// Multi-flop synchroniser for a single asynchronous level signal.
//
// Parameters:
//   STAGES : number of flops in the chain (at least 2)
//
// Ports:
//   clock  : destination clock
//   resetn : asynchronous active-low clear of every flop
//   d      : asynchronous input level
//   q      : synchronised level (output of the last flop)
// ---------------------------------------------------------------------------
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// pll_reset_sequencer
//
// Holds a downstream clock domain in reset until the PLL lock flag has been
// stable for STABLE_CYCLES cycles, then stretches the reset for HOLD_CYCLES
// more cycles before releasing it. Any loss of lock drops straight back to
// WAIT and re-asserts the downstream reset. A single-cycle software request
// in RUN re-pulses the reset for HOLD_CYCLES cycles.
//
// Optional feature: define PLL_RESET_SEQUENCER_LOSS_COUNT_EN to add the
// 8-bit saturating lock-loss counter and its `loss_count` port.
//
// Parameters:
//   SYNC_STAGES   : synchroniser depth on `locked` (>= 2)
//   STABLE_CYCLES : cycles `locked` must stay high before acceptance (>= 1)
//   HOLD_CYCLES   : reset-stretch cycles after acceptance (>= 1)
//
// Ports:
//   clock      : PLL output clock
//   resetn     : asynchronous active-low reset
//   locked     : PLL lock flag, asynchronous to `clock`
//   sw_reset   : single-cycle request to re-pulse the downstream reset
//   rst_out_n  : registered active-low downstream reset
//   ready      : high while in RUN
//   state      : current state encoding (WAIT=0 QUALIFY=1 HOLD=2 RUN=3)
//   loss_count : RUN->WAIT transition count, saturating at 255 (optional)
// ---------------------------------------------------------------------------
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       locked,
    input  logic       sw_reset,
    output logic       rst_out_n,
    output logic       ready,
    output logic [1:0] state
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int CW = counter_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    logic          locked_s;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          rst_q;

    // Only the synchronised copy of `locked` is used below.
    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock  (clock),
        .resetn (resetn),
        .d      (locked),
        .q      (locked_s)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= WAIT;
            cnt_q   <= '0;
            rst_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Registered from the next state so the reset releases on the
            // same edge that the state enters RUN.
            rst_q   <= (state_d == RUN);
        end
    end

    // Lock loss is tested first in every locked-dependent state, which gives
    // it priority over sw_reset. The counter stops at its terminal value
    // because each terminal compare leaves the state instead of counting on.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT: begin
                if (locked_s) begin
                    state_d = QUALIFY;
                    cnt_d   = '0;
                end
            end
            QUALIFY: begin
                if (!locked_s) begin
                    state_d = WAIT;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT;
                end else if (sw_reset) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign rst_out_n = rst_q;
    assign ready     = (state_q == RUN);
    assign state     = state_q;

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    logic [7:0] loss_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            loss_q <= 8'd0;
        end else if ((state_q == RUN) && (state_d == WAIT) && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
        end
    end

    assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Bench for pll_reset_sequencer with SYNC_STAGES=2, STABLE_CYCLES=4,
// HOLD_CYCLES=3. The reference model tracks how long the synchronised lock
// flag has been continuously high (a "streak" length) and derives the
// expected state from that length; sw_reset in RUN rewinds the streak to the
// start of the hold window. Define PLL_RESET_SEQUENCER_LOSS_COUNT_EN to
// exercise the loss counter.
// ---------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 4;
    localparam int HOLDC  = 3;
    localparam int RUN_K  = STABLE + HOLDC + 1;

    logic       clock;
    logic       resetn;
    logic       locked;
    logic       sw_reset;
    logic       rst_out_n;
    logic       ready;
    logic [1:0] state;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    logic [7:0] loss_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic hist[$];
    int   k;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
    int   exp_loss;
`endif

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLDC)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .locked    (locked),
        .sw_reset  (sw_reset),
        .rst_out_n (rst_out_n),
        .ready     (ready),
        .state     (state)
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
        ,
        .loss_count(loss_count)
`endif
    );

    // Clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected state from the current lock streak length.
    function automatic logic [1:0] exp_state(input int kk);
        if (kk == 0)                 return 2'd0;
        else if (kk <= STABLE)       return 2'd1;
        else if (kk <= STABLE+HOLDC) return 2'd2;
        else                         return 2'd3;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
        k = 0;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
        exp_loss = 0;
`endif
    endtask

    // Advance the model by one edge with the inputs that edge samples.
    task automatic model_edge(input logic lk, input logic sw);
        logic ls;
        logic was_run;
        ls = hist.pop_front();
        hist.push_back(lk);
        was_run = (exp_state(k) == 2'd3);
        if (!ls)                 k = 0;
        else if (was_run && sw)  k = STABLE + 1;
        else if (k < RUN_K)      k = k + 1;
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
        if (was_run && k == 0 && exp_loss < 255) exp_loss++;
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"},     {6'd0, state},     {6'd0, exp_state(k)});
        check({tag, ".rst_out_n"}, {7'd0, rst_out_n}, {7'd0, exp_state(k) == 2'd3});
        check({tag, ".ready"},     {7'd0, ready},     {7'd0, exp_state(k) == 2'd3});
`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
        check({tag, ".loss_count"}, loss_count, 8'(exp_loss));
`endif
    endtask

    // Drive inputs, take one clock edge, check #1 after the edge.
    task automatic step(input string tag, input logic lk, input logic sw);
        locked   = lk;
        sw_reset = sw;
        @(posedge clock);
        model_edge(lk, sw);
        #1;
        check_outputs(tag);
    endtask

    // Hold locked high and report the index of the first edge after which
    // rst_out_n is high (edge 0 is the first edge sampling locked high).
    task automatic edges_to_release(input string tag, output int n);
        n = -1;
        for (int i = 0; i < 30; i++) begin
            step(tag, 1'b1, 1'b0);
            if (rst_out_n === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    int  n_edges;
    bit  seen_rst;
    logic lk_r;

    initial begin
        // Reset
        resetn   = 1'b0;
        locked   = 1'b0;
        sw_reset = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        resetn = 1'b1;
        #1;

        // Lock from WAIT: release after 2+4+3 = 9 edges
        edges_to_release("lock_up", n_edges);
        check("lock_up.edges", 8'(n_edges), 8'd9);
        repeat (3) step("run_steady", 1'b1, 1'b0);

        // Software reset: low for exactly 3 cycles, then RUN again
        step("sw_reset", 1'b1, 1'b1);
        check("sw_reset.state", {6'd0, state}, 8'd2);
        repeat (2) step("sw_hold", 1'b1, 1'b0);
        check("sw_hold.rst_low", {7'd0, rst_out_n}, 8'd0);
        step("sw_back", 1'b1, 1'b0);
        check("sw_back.state", {6'd0, state}, 8'd3);

        // sw_reset on the edge where locked_s falls: WAIT wins over HOLD
        step("drop0", 1'b0, 1'b0);
        step("drop1", 1'b0, 1'b0);
        step("drop_sw", 1'b0, 1'b1);
        check("drop_sw.state", {6'd0, state}, 8'd0);
        repeat (3) step("wait_low", 1'b0, 1'b0);

        // Relock: full 9-edge sequence again
        edges_to_release("relock", n_edges);
        check("relock.edges", 8'(n_edges), 8'd9);

        // Lock drop from RUN: rst_out_n low 2 edges later
        step("loss_e0", 1'b0, 1'b0);
        check("loss_e0.rst", {7'd0, rst_out_n}, 8'd1);
        step("loss_e1", 1'b0, 1'b0);
        step("loss_e2", 1'b0, 1'b0);
        check("loss_e2.rst", {7'd0, rst_out_n}, 8'd0);
        repeat (2) step("loss_settle", 1'b0, 1'b0);

        // Short lock pulse: back to WAIT from QUALIFY, no release
        seen_rst = 1'b0;
        repeat (3) step("pulse_hi", 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step("pulse_lo", 1'b0, 1'b0);
            if (rst_out_n === 1'b1) seen_rst = 1'b1;
        end
        check("pulse.no_release", {7'd0, seen_rst}, 8'd0);

        // Randomised lock stretches with occasional sw_reset
        lk_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 11) == 0) lk_r = ~lk_r;
            step("random", lk_r, ($urandom_range(0, 7) == 0));
        end

        // Asynchronous reset during HOLD, then full restart
        repeat (3) step("pre_hold_lo", 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (exp_state(k) == 2'd2) break;
            step("to_hold", 1'b1, 1'b0);
        end
        check("to_hold.state", {6'd0, state}, 8'd2);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        #1;
        resetn = 1'b1;
        edges_to_release("after_reset", n_edges);
        check("after_reset.edges", 8'(n_edges), 8'd9);

`ifdef PLL_RESET_SEQUENCER_LOSS_COUNT_EN
        // 256 lock losses saturate the counter at 255
        for (int j = 0; j < 256; j++) begin
            for (int i = 0; i < 12; i++) begin
                if (exp_state(k) == 2'd3) break;
                step("sat_up", 1'b1, 1'b0);
            end
            repeat (3) step("sat_down", 1'b0, 1'b0);
        end
        check("saturate.loss_count", loss_count, 8'd255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops on `locked` (minimum 2).
REQ-002 SHALL have parameter STABLE_CYCLES, default 1024, the number of cycles `locked` must stay high before lock is accepted (minimum 1).
REQ-003 SHALL have parameter HOLD_CYCLES, default 16, the number of reset-stretch cycles after lock is accepted (minimum 1).
REQ-004 SHALL have port `clock`, input, 1 bit: the single clock, a PLL output clock.
REQ-005 SHALL have port `resetn`, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port `locked`, input, 1 bit: PLL lock flag, asynchronous to `clock`.
REQ-007 SHALL have port `sw_reset`, input, 1 bit: single-cycle software request to re-pulse the downstream reset.
REQ-008 SHALL have port `rst_out_n`, output, 1 bit: active-low downstream domain reset, driven from a register.
REQ-009 SHALL have port `ready`, output, 1 bit: high while in state RUN.
REQ-010 SHALL have port `state`, output, 2 bits: current state encoding.
REQ-011 SHALL have port `loss_count`, output, 8 bits: lock-loss counter, present only when the configuration macro is defined.

Function
REQ-012 SHALL pass `locked` through SYNC_STAGES flops to produce `locked_s`; no other logic SHALL use raw `locked`.
REQ-013 SHALL implement four states: WAIT=0, QUALIFY=1, HOLD=2, RUN=3.
REQ-014 WAIT: if `locked_s`=1, go to QUALIFY and clear the counter; otherwise remain in WAIT.
REQ-015 QUALIFY: if `locked_s`=0, go to WAIT; if counter=STABLE_CYCLES-1, go to HOLD and clear the counter; otherwise increment the counter.
REQ-016 HOLD: if `locked_s`=0, go to WAIT; if counter=HOLD_CYCLES-1, go to RUN; otherwise increment the counter.
REQ-017 RUN: if `locked_s`=0, go to WAIT; else if `sw_reset`=1, go to HOLD and clear the counter; otherwise remain in RUN.
REQ-018 SHALL give lock loss priority over `sw_reset` when both occur in the same cycle; `sw_reset` SHALL be ignored outside RUN.
REQ-019 SHALL register `rst_out_n` as (next state == RUN), so that it deasserts on the same edge on which the state enters RUN.
REQ-020 With `locked` first sampled high at edge e0 and staying high, `rst_out_n` SHALL rise at edge e(SYNC_STAGES+STABLE_CYCLES+HOLD_CYCLES).
REQ-021 With `locked` first sampled low at edge e0 while in RUN, `rst_out_n` SHALL fall at edge e(SYNC_STAGES).
REQ-022 SHALL size the counter to clog2(max(STABLE_CYCLES,HOLD_CYCLES)) bits, and it SHALL never wrap.

Reset
REQ-023 While `resetn`=0, SHALL force all synchroniser flops to 0, the state to WAIT, the counter to 0, `rst_out_n`=0, `ready`=0 and `loss_count`=0.
REQ-024 Assertion of `resetn` mid-sequence SHALL abort the sequence immediately; after release, the full qualify and hold sequence SHALL restart.

Configuration
REQ-025 SHALL provide macro PLL_RESET_SEQUENCER_LOSS_COUNT_EN.
REQ-026 When PLL_RESET_SEQUENCER_LOSS_COUNT_EN is defined, `loss_count` SHALL increment on each RUN->WAIT transition and saturate at 255.
REQ-027 When PLL_RESET_SEQUENCER_LOSS_COUNT_EN is undefined, the `loss_count` port and its counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 SHALL place the state typedef (2-bit enum WAIT/QUALIFY/HOLD/RUN) and the default parameter constants in shared package `pll_reset_pkg`.
REQ-029 SHALL implement the synchroniser as sub-module `lock_sync` (parameter STAGES, with async active-low clear).

Verification
REQ-030 Parameters SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=3; `locked` rises before e0 and stays high -> `rst_out_n` and `ready` rise at e9, `state` sequence is 0,1,2,3.
REQ-031 Same parameters; `locked` pulses high for 3 cycles, then low -> `state` returns to WAIT from QUALIFY, and `rst_out_n` never rises.
REQ-032 In RUN, `locked` drops at e0 -> `rst_out_n`=0 at e2, `state`=0, `loss_count` 0->1; on relock, the full 9-cycle sequence repeats.
REQ-033 In RUN, single-cycle `sw_reset` -> `rst_out_n` low for exactly 3 cycles, `state` goes HOLD->RUN, `loss_count` unchanged.
REQ-034 `sw_reset` in the same cycle that `locked_s` falls in RUN -> next state is WAIT, not HOLD.
REQ-035 `resetn` pulsed low during HOLD -> all outputs are 0 asynchronously; after release, `rst_out_n` rises 9 edges after the first edge that samples `locked` high; with the macro defined, 256 lock losses leave `loss_count`=255.
